pulse_stretch: RTL and testbench
================================

Name: pulse_stretch

Overview:
- Output-side counterpart to the input debouncer. It turns single-cycle event pulses into human-visible blinks on a board output such as an LED, buzzer or strobe pin.
- Each accepted event produces exactly one high period of fixed minimum length, followed by a mandatory low gap.
- Events arriving during a blink are queued as a count, so no event is merged or lost until the queue saturates.
- Typical source: the debouncer's rising-edge or falling-edge event pulses.

Parameters:
- HOLD_CYCLES_L2, 10, high time = 2^HOLD_CYCLES_L2 i_clk cycles (range 1..24)
- GAP_CYCLES_L2, 10, low gap = 2^GAP_CYCLES_L2 i_clk cycles (range 0..24)
- PEND_W, 3, width of the pending-event counter; max queued = 2^PEND_W-1 (range 1..8)

Ports:
- i_clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- i_pulse  in  1  event request; each cycle high counts as one event
- i_clr_ovf  in  1  synchronous clear of o_overflow
- o_dout  out  1  stretched output; registered, glitch-free
- o_busy  out  1  high while in ON or OFF state
- o_start  out  1  one-cycle pulse, coincident with the first cycle o_dout=1
- o_done  out  1  one-cycle pulse on the last cycle of a gap
- o_pending  out  PEND_W  queued events not yet started
- o_overflow  out  1  sticky flag: an event was dropped

Behaviour:
- Clock i_clk; reset is asynchronous, active-high, named reset.
- All outputs are registered.
- On reset: state=IDLE, counter=0, and every output is 0 (o_dout, o_busy, o_start, o_done, o_pending, o_overflow).
- FSM states: IDLE, ON, OFF. A single shared counter of width max(HOLD_CYCLES_L2, GAP_CYCLES_L2, 1) is cleared on every state change.
- IDLE:
  - If i_pulse=1 or pending>0, go to ON on the next edge.
  - If pending>0, consume one pending event and ignore a simultaneous i_pulse for start purposes, but enqueue it.
  - Latency: i_pulse high in cycle N gives o_dout=1 and o_start=1 in cycle N+1.
- ON:
  - o_dout=1 for exactly 2^HOLD_CYCLES_L2 cycles.
  - At terminal count (counter == 2^HOLD_CYCLES_L2-1), go to OFF.
- OFF:
  - o_dout=0 for exactly 2^GAP_CYCLES_L2 cycles.
  - o_done=1 on the final OFF cycle.
  - At terminal count:
    - if pending>0, go to ON, consuming one event;
    - else if i_pulse=1 that cycle, go to ON without touching pending;
    - else go to IDLE.
  - Back-to-back blinks therefore have no IDLE cycle between them.
- o_busy=1 exactly when state is ON or OFF.
- Enqueue rule: i_pulse=1 while state is ON or OFF, except when it is consumed directly per the rules above, increments pending.
- Simultaneous enqueue and consume: pending is unchanged.
- Saturation: an enqueue at pending = 2^PEND_W-1 is dropped and o_overflow is set on the next edge.
- o_overflow is cleared by i_clr_ovf=1. If i_clr_ovf and a new overflow occur in the same cycle, set wins.
- A pulse is never lost silently: every i_pulse cycle either starts a blink, increments pending, or sets o_overflow.
- Reset mid-blink: o_dout drops asynchronously, the queue is flushed, and no o_done is produced.
- The input is not synchronized inside this block. i_pulse must already be synchronous to i_clk.

Decomposition:
- Package pulse_stretch_pkg holds:
  - typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF} ps_state_t;
  - a function that returns the counter width from the parameters.
- One natural sub-module, term_cntr: parameterized width, synchronous clear, enable, and an o_tc terminal-count flag.
  - It is instantiated once and shared by ON and OFF, with a per-state terminal value.
  - Its reset is the same asynchronous reset.
- Pending counter and overflow logic stay in the top level.

Test Plan:
Bench parameters: HOLD_CYCLES_L2=2, GAP_CYCLES_L2=1, PEND_W=2.
1. Single pulse at cycle 10 -> o_start and o_dout=1 at cycle 11; o_dout high cycles 11-14; low cycles 15-16; o_done at 16; o_busy=0 and IDLE from 17.
2. Pulses at cycles 10, 12 and 13 -> o_pending goes 1 then 2; three blinks start at cycles 11, 17 and 23 with no idle between; o_pending ends at 0; three o_done pulses.
3. Five pulses on consecutive cycles 10-14 -> one blink starts and pending saturates at 3; the 5th pulse sets o_overflow at cycle 15; exactly 4 blinks are observed. i_clr_ovf at cycle 40 -> o_overflow=0 at 41.
4. Pulse arriving exactly on the final gap cycle (cycle 16) with pending=0 -> next blink starts at 17; o_pending stays 0 throughout.
5. Reset asserted asynchronously at mid-ON cycle 12 with pending=2 -> o_dout=0 immediately, all outputs 0; no blink after release until a new i_pulse.
6. i_clr_ovf and an overflowing pulse in the same cycle -> o_overflow remains 1.

Source files
------------

// File: rtl/pulse_stretch_pkg.sv
// Shared types and helpers for the pulse stretcher: FSM state encoding and
// the width of the counter shared by the ON and OFF phases.
package pulse_stretch_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF} ps_state_t;

    function automatic int cntr_width(input int hold_l2, input int gap_l2);
        int w;
        w = (hold_l2 > gap_l2) ? hold_l2 : gap_l2;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/term_cntr.sv
// Up-counter with synchronous clear and enable; o_tc flags that the count
// equals the caller-supplied terminal value.
module term_cntr
    import pulse_stretch_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_tc_val,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            o_cnt <= '0;
        end else if (i_clr) begin
            o_cnt <= '0;
        end else if (i_en) begin
            o_cnt <= o_cnt + W'(1);
        end
    end

    assign o_tc = (o_cnt == i_tc_val);

endmodule

// File: rtl/pulse_stretch.sv
// Stretches single-cycle event pulses into fixed-length blinks with a
// mandatory low gap; events arriving during a blink are queued as a count.
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int HOLD_CYCLES_L2 = 10,
    parameter int GAP_CYCLES_L2  = 10,
    parameter int PEND_W         = 3
) (
    input  logic              i_clk,
    input  logic              reset,
    input  logic              i_pulse,
    input  logic              i_clr_ovf,
    output logic              o_dout,
    output logic              o_busy,
    output logic              o_start,
    output logic              o_done,
    output logic [PEND_W-1:0] o_pending,
    output logic              o_overflow
);

    localparam int CW = cntr_width(HOLD_CYCLES_L2, GAP_CYCLES_L2);
    localparam logic [CW-1:0] HOLD_TC   = CW'((64'd1 << HOLD_CYCLES_L2) - 64'd1);
    localparam logic [CW-1:0] GAP_TC    = CW'((64'd1 << GAP_CYCLES_L2) - 64'd1);
    localparam logic [CW-1:0] GAP_TC_M1 = GAP_TC - CW'(1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    ps_state_t         state, state_d;
    logic [CW-1:0]     cnt, tc_val;
    logic              tc;
    logic              has_pend, can_start, consume, enqueue, ovf_set;
    logic [PEND_W-1:0] pend_d;
    logic              ovf_d, done_d, start_d;

    term_cntr #(.W(CW)) u_cntr (
        .i_clk    (i_clk),
        .reset    (reset),
        .i_clr    (state_d != state),
        .i_en     (state != ST_IDLE),
        .i_tc_val (tc_val),
        .o_cnt    (cnt),
        .o_tc     (tc)
    );

    always_comb begin
        tc_val    = (state == ST_OFF) ? GAP_TC : HOLD_TC;
        has_pend  = (o_pending != '0);
        can_start = (state == ST_IDLE) || ((state == ST_OFF) && tc);
        state_d   = state;
        case (state)
            ST_IDLE: if (i_pulse || has_pend) state_d = ST_ON;
            ST_ON:   if (tc) state_d = ST_OFF;
            ST_OFF:  if (tc) state_d = (has_pend || i_pulse) ? ST_ON : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A queued event always has priority over a fresh pulse at a start point;
        // the fresh pulse is then queued in its place.
        consume = can_start && has_pend;
        enqueue = i_pulse && !(can_start && !has_pend);
        ovf_set = enqueue && !consume && (o_pending == PEND_MAX);
        pend_d  = o_pending;
        if (enqueue && !consume && !ovf_set) begin
            pend_d = o_pending + PEND_W'(1);
        end else if (consume && !enqueue) begin
            pend_d = o_pending - PEND_W'(1);
        end
        ovf_d = ovf_set ? 1'b1 : (i_clr_ovf ? 1'b0 : o_overflow);

        // Outputs are registered, so done/start are decoded one cycle ahead.
        start_d = (state_d == ST_ON) && (state != ST_ON);
        done_d  = (state_d == ST_OFF) &&
                  ((state != ST_OFF) ? (GAP_CYCLES_L2 == 0) : (cnt == GAP_TC_M1));
    end

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            o_dout     <= 1'b0;
            o_busy     <= 1'b0;
            o_start    <= 1'b0;
            o_done     <= 1'b0;
            o_pending  <= '0;
            o_overflow <= 1'b0;
        end else begin
            state      <= state_d;
            o_dout     <= (state_d == ST_ON);
            o_busy     <= (state_d != ST_IDLE);
            o_start    <= start_d;
            o_done     <= done_d;
            o_pending  <= pend_d;
            o_overflow <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed and randomized bench for pulse_stretch, checked against a
// blink-timeline reference model.
module tb_pulse_stretch;

    localparam int H      = 2;
    localparam int G      = 1;
    localparam int P      = 2;
    localparam int HOLD   = 1 << H;
    localparam int PERIOD = (1 << H) + (1 << G);
    localparam int MAXP   = (1 << P) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         pulse;
    logic         clr_ovf;
    logic         o_dout, o_busy, o_start, o_done, o_overflow;
    logic [P-1:0] o_pending;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc;
    int m_t, m_pend, m_ovf;
    int starts[$];
    int dones[$];
    int max_pend;
    int first_ovf;

    always #5 clk = ~clk;

    pulse_stretch #(
        .HOLD_CYCLES_L2 (H),
        .GAP_CYCLES_L2  (G),
        .PEND_W         (P)
    ) dut (
        .i_clk      (clk),
        .reset      (reset),
        .i_pulse    (pulse),
        .i_clr_ovf  (clr_ovf),
        .o_dout     (o_dout),
        .o_busy     (o_busy),
        .o_start    (o_start),
        .o_done     (o_done),
        .o_pending  (o_pending),
        .o_overflow (o_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): observed %0d expected %0d", tag, cyc + 1, obs, exp);
        end
    endtask

    // m_t = cycles since the current blink began, -1 when idle
    task automatic model_step(input logic p, input logic c);
        bit set_ovf;
        set_ovf = 1'b0;
        if (m_t < 0 || m_t == PERIOD - 1) begin
            if (m_pend > 0) begin
                m_t = 0;
                if (!p) m_pend--;
            end else if (p) begin
                m_t = 0;
            end else begin
                m_t = -1;
            end
        end else begin
            m_t++;
            if (p) begin
                if (m_pend == MAXP) set_ovf = 1'b1;
                else m_pend++;
            end
        end
        if (set_ovf) m_ovf = 1;
        else if (c) m_ovf = 0;
    endtask

    task automatic check_all();
        chk("dout",     32'(o_dout),     32'(m_t >= 0 && m_t < HOLD));
        chk("busy",     32'(o_busy),     32'(m_t >= 0));
        chk("start",    32'(o_start),    32'(m_t == 0));
        chk("done",     32'(o_done),     32'(m_t == PERIOD - 1));
        chk("pending",  32'(o_pending),  32'(m_pend));
        chk("overflow", 32'(o_overflow), 32'(m_ovf));
    endtask

    task automatic step(input logic p, input logic c);
        @(negedge clk);
        pulse   = p;
        clr_ovf = c;
        cyc++;
        @(posedge clk);
        model_step(p, c);
        #1;
        check_all();
        if (o_start === 1'b1) starts.push_back(cyc + 1);
        if (o_done === 1'b1) dones.push_back(cyc + 1);
        if (int'(o_pending) > max_pend) max_pend = int'(o_pending);
        if (o_overflow === 1'b1 && first_ovf < 0) first_ovf = cyc + 1;
    endtask

    task automatic begin_test();
        cyc = 0;
        starts.delete();
        dones.delete();
        max_pend  = 0;
        first_ovf = -1;
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        m_t = -1; m_pend = 0; m_ovf = 0;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; pulse = 1'b0; clr_ovf = 1'b0;
        m_t = -1; m_pend = 0; m_ovf = 0;
        cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;

        // single pulse
        begin_test();
        for (int k = 1; k <= 25; k++) step(k == 10, 1'b0);
        chk("t1_nstart", 32'(starts.size()), 32'd1);
        chk("t1_start",  32'(starts[0]), 32'd11);
        chk("t1_done",   32'(dones[0]), 32'd16);

        // queued pulses, back-to-back blinks
        begin_test();
        for (int k = 1; k <= 35; k++) step(k == 10 || k == 12 || k == 13, 1'b0);
        chk("t2_nstart", 32'(starts.size()), 32'd3);
        chk("t2_start0", 32'(starts[0]), 32'd11);
        chk("t2_start1", 32'(starts[1]), 32'd17);
        chk("t2_start2", 32'(starts[2]), 32'd23);
        chk("t2_ndone",  32'(dones.size()), 32'd3);
        chk("t2_maxpend", 32'(max_pend), 32'd2);
        chk("t2_pend_end", 32'(o_pending), 32'd0);

        // saturation and overflow clear
        begin_test();
        for (int k = 1; k <= 39; k++) step(k >= 10 && k <= 14, 1'b0);
        chk("t3_first_ovf", 32'(first_ovf), 32'd15);
        chk("t3_ovf_held", 32'(o_overflow), 32'd1);
        step(1'b0, 1'b1);
        chk("t3_ovf_clr", 32'(o_overflow), 32'd0);
        chk("t3_nstart", 32'(starts.size()), 32'd4);

        // pulse on the final gap cycle starts directly
        begin_test();
        for (int k = 1; k <= 30; k++) step(k == 10 || k == 16, 1'b0);
        chk("t4_nstart",  32'(starts.size()), 32'd2);
        chk("t4_start1",  32'(starts[1]), 32'd17);
        chk("t4_maxpend", 32'(max_pend), 32'd0);

        // asynchronous reset mid-blink with a non-empty queue
        begin_test();
        for (int k = 1; k <= 12; k++) step(k >= 10, 1'b0);
        chk("t5_pend_pre", 32'(o_pending), 32'd2);
        async_reset();
        chk("t5_dout_rst", 32'(o_dout), 32'd0);
        begin_test();
        for (int k = 1; k <= 20; k++) step(1'b0, 1'b0);
        chk("t5_nstart", 32'(starts.size()), 32'd0);

        // overflow set wins over a simultaneous clear
        begin_test();
        for (int k = 1; k <= 4; k++) step(1'b1, 1'b0);
        chk("t6_ovf_pre", 32'(o_overflow), 32'd0);
        step(1'b1, 1'b1);
        chk("t6_ovf_set_wins", 32'(o_overflow), 32'd1);
        for (int k = 1; k <= 30; k++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);

        // randomized traffic
        begin_test();
        for (int k = 1; k <= 600; k++) begin
            step($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 4);
            if (k == 300) async_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
